// File: rtl/bitstream_mem_writer_if.sv
// rtl/bitstream_mem_writer_if.sv - host bit stream and block-memory write port bundle
interface bitstream_mem_writer_if #(
    parameter int ADDR_W = 14
);
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic              mem_ena;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addra;
    logic              mem_dina;

    modport master (
        input  bit_in, bit_valid,
        output bit_ready, mem_ena, mem_wea, mem_addra, mem_dina
    );

    modport slave (
        output bit_in, bit_valid,
        input  bit_ready, mem_ena, mem_wea, mem_addra, mem_dina
    );
endinterface

// File: rtl/bitstream_mem_writer.sv
// rtl/bitstream_mem_writer.sv - fills 1-bit block memory from LFSR/pattern/host and counts 1011 matches
module bitstream_mem_writer #(
    parameter int              ADDR_W    = 14,
    parameter logic [15:0]     LFSR_SEED = 16'hACE1,
    parameter logic [7:0]      PATTERN   = 8'b10110010
) (
    input  logic                      clock_100Mhz,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic [1:0]                src_sel_i,
    input  logic [ADDR_W-1:0]         fill_len_i,
    bitstream_mem_writer_if.master    bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [15:0]               golden_count_o
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    typedef enum logic [1:0] {D_S0, D_S1, D_S2, D_S3} det_t;

    localparam logic [1:0] SRC_LFSR = 2'b00;
    localparam logic [1:0] SRC_PAT  = 2'b01;
    localparam logic [1:0] SRC_HOST = 2'b10;

    state_t            state_q, state_d;
    det_t              det_q, det_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        src_q, src_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [2:0]        pidx_q, pidx_d;

    logic write_en;
    logic cur_bit;
    logic ready;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            det_q   <= D_S0;
            len_q   <= '0;
            addr_q  <= '0;
            src_q   <= SRC_LFSR;
            count_q <= '0;
            lfsr_q  <= LFSR_SEED;
            pidx_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            pidx_q  <= pidx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        det_d    = det_q;
        len_d    = len_q;
        addr_d   = addr_q;
        src_d    = src_q;
        count_d  = count_q;
        lfsr_d   = lfsr_q;
        pidx_d   = pidx_q;
        write_en = 1'b0;
        cur_bit  = 1'b0;
        ready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    len_d   = fill_len_i;
                    // the reserved encoding behaves as the LFSR source
                    src_d   = (src_sel_i == 2'b11) ? SRC_LFSR : src_sel_i;
                end
            end
            LOAD: begin
                state_d = WRITE;
                addr_d  = '0;
                count_d = '0;
                det_d   = D_S0;
                lfsr_d  = LFSR_SEED;
                pidx_d  = 3'd7;
            end
            WRITE: begin
                ready    = (src_q == SRC_HOST);
                write_en = (src_q == SRC_HOST) ? bus.bit_valid : 1'b1;
                case (src_q)
                    SRC_HOST: cur_bit = bus.bit_in;
                    SRC_PAT:  cur_bit = PATTERN[pidx_q];
                    default:  cur_bit = lfsr_q[0];
                endcase
                if (write_en) begin
                    if (src_q == SRC_LFSR)
                        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                    if (src_q == SRC_PAT)
                        pidx_d = pidx_q - 3'd1;
                    // matches restart from S0 so counted occurrences never overlap
                    case (det_q)
                        D_S0: det_d = cur_bit ? D_S1 : D_S0;
                        D_S1: det_d = cur_bit ? D_S1 : D_S2;
                        D_S2: det_d = cur_bit ? D_S3 : D_S0;
                        default: begin
                            det_d = cur_bit ? D_S0 : D_S2;
                            if (cur_bit && count_q != 16'hFFFF)
                                count_d = count_q + 16'd1;
                        end
                    endcase
                    if (addr_q == len_q)
                        state_d = DONE;
                    else
                        addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.bit_ready   = ready;
    assign bus.mem_ena     = write_en;
    assign bus.mem_wea     = write_en;
    assign bus.mem_dina    = write_en & cur_bit;
    assign bus.mem_addra   = addr_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign golden_count_o  = count_q;
endmodule

// File: tb/tb_bitstream_mem_writer.sv
// tb/tb_bitstream_mem_writer.sv - scoreboard bench for bitstream_mem_writer
module tb_bitstream_mem_writer;
    localparam int          ADDR_W = 14;
    localparam logic [7:0]  PAT    = 8'b10110010;
    localparam int          SEED   = 'hACE1;

    logic              clock_100Mhz = 1'b0;
    logic              reset        = 1'b1;
    logic              start        = 1'b0;
    logic [1:0]        src_sel      = 2'b00;
    logic [ADDR_W-1:0] fill_len     = '0;
    logic              busy;
    logic              done;
    logic [15:0]       golden_count;

    bitstream_mem_writer_if #(.ADDR_W(ADDR_W)) bus ();

    bitstream_mem_writer #(.ADDR_W(ADDR_W)) dut (
        .clock_100Mhz   (clock_100Mhz),
        .reset          (reset),
        .start_i        (start),
        .src_sel_i      (src_sel),
        .fill_len_i     (fill_len),
        .bus            (bus),
        .busy_o         (busy),
        .done_o         (done),
        .golden_count_o (golden_count)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    typedef struct {
        int addr;
        bit data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_cnt[$];
    int  checks = 0;
    int  errors = 0;
    bit  empty_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_100Mhz);
        #1;
    endtask

    // reference bit stream of a fill, straight from the source definitions
    task automatic build_bits(input int src, input int len, input bit host[$], output bit bits[$]);
        int lfsr;
        int fb;
        bits = {};
        lfsr = SEED;
        for (int i = 0; i <= len; i++) begin
            if (src == 1) begin
                bits.push_back(PAT[7 - (i % 8)]);
            end else if (src == 2) begin
                bits.push_back(host[i]);
            end else begin
                bits.push_back(lfsr[0]);
                fb   = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
                lfsr = (lfsr >> 1) | (fb << 15);
            end
        end
    endtask

    function automatic int count1011(input bit b[$]);
        int n = 0;
        int i = 0;
        while (i + 3 < b.size()) begin
            if (b[i] && !b[i+1] && b[i+2] && b[i+3]) begin
                n++;
                i += 4;
            end else begin
                i++;
            end
        end
        return (n > 65535) ? 65535 : n;
    endfunction

    task automatic expect_fill(input int src, input int len, input bit host[$], output int cnt);
        bit bits[$];
        wr_t w;
        build_bits(src, len, host, bits);
        for (int i = 0; i <= len; i++) begin
            w.addr = i;
            w.data = bits[i];
            exp_wr.push_back(w);
        end
        cnt = count1011(bits);
        exp_cnt.push_back(cnt);
    endtask

    // monitor: every write and every done pulse is checked against the scoreboard
    always @(negedge clock_100Mhz) begin
        if (!reset) begin
            if (bus.mem_ena || bus.mem_wea) begin
                check("ena_eq_wea", bus.mem_ena, bus.mem_wea);
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d with nothing expected",
                             bus.mem_addra, bus.mem_dina);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("write_addr", bus.mem_addra, w.addr);
                    check("write_data", bus.mem_dina, w.data);
                end
            end else begin
                check("dina_idle", bus.mem_dina, 0);
            end
            if (done) begin
                check("busy_at_done", busy, 1);
                check("writes_left_at_done", exp_wr.size(), 0);
                if (exp_cnt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: count %0d with no fill expected", golden_count);
                end else begin
                    check("golden_count", golden_count, exp_cnt.pop_front());
                end
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (n < 20000) begin
            @(negedge clock_100Mhz);
            if (done) break;
            n++;
        end
        if (n == 20000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, busy=%0d", n, busy);
        end
        tick();
        check("idle_after_done", busy, 0);
    endtask

    task automatic scramble();
        fill_len = ADDR_W'($urandom);
        src_sel  = 2'($urandom);
    endtask

    task automatic run_fill(input int src, input int len, input bit host[$],
                            input int valid_mode, input int restart_at);
        int cnt;
        int idx;
        int cyc;
        bit pulsed;
        expect_fill(src, len, host, cnt);
        fill_len = ADDR_W'(len);
        src_sel  = 2'(src);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        if (src == 2) begin
            idx = 0;
            cyc = 0;
            pulsed = 1'b0;
            while (idx <= len && cyc < 5000) begin
                bus.bit_valid = (valid_mode == 1) ? cyc[0] : 1'($urandom);
                bus.bit_in    = bus.bit_valid ? host[idx] : 1'($urandom);
                if (cyc == 1) scramble();
                if (restart_at >= 0 && !pulsed && idx == restart_at) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clock_100Mhz);
                if (bus.bit_valid && bus.bit_ready) idx++;
                tick();
                cyc++;
            end
            bus.bit_valid = 1'b0;
            start         = 1'b0;
            if (cyc == 5000) begin
                checks++;
                errors++;
                $display("FAIL host_feed_timeout: accepted %0d of %0d bits", idx, len + 1);
            end
        end else begin
            tick();
            scramble();
            if (restart_at >= 0) begin
                repeat (restart_at) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        wait_done();
        tick();
        check("count_hold_idle", golden_count, cnt);
    endtask

    initial begin
        bit h[$];
        int n;
        int cnt;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;

        repeat (3) @(posedge clock_100Mhz);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", golden_count, 0);
        check("rst_wea", bus.mem_wea, 0);
        check("rst_addr", bus.mem_addra, 0);
        check("rst_ready", bus.bit_ready, 0);
        reset = 1'b0;
        tick();

        run_fill(1, 7, empty_q, 0, -1);
        check("pattern_count", golden_count, 1);

        h = {1, 0, 1, 1, 1, 0, 1, 1};
        run_fill(2, 7, h, 1, -1);
        check("host_alt_count", golden_count, 2);

        run_fill(0, 3, empty_q, 0, -1);

        expect_fill(1, 0, empty_q, cnt);
        fill_len = '0;
        src_sel  = 2'b01;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clock_100Mhz);
            if (busy) n++;
        end
        check("len0_busy_cycles", n, 3);
        tick();

        h = {1, 0, 1, 1, 0, 1, 1};
        run_fill(2, 6, h, 0, 3);
        check("restart_ignored_count", golden_count, 1);

        run_fill(1, 40, empty_q, 0, 10);

        expect_fill(1, 200, empty_q, cnt);
        fill_len = ADDR_W'(200);
        src_sel  = 2'b01;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (30) tick();
        check("pre_reset_count_nonzero", golden_count != 0, 1);
        reset = 1'b1;
        exp_wr.delete();
        exp_cnt.delete();
        #1;
        check("midrst_wea", bus.mem_wea, 0);
        check("midrst_ena", bus.mem_ena, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", golden_count, 0);
        check("midrst_addr", bus.mem_addra, 0);
        tick();
        reset = 1'b0;
        tick();
        run_fill(0, 5, empty_q, 0, -1);

        run_fill(3, 20, empty_q, 0, -1);
        run_fill(0, 2000, empty_q, 0, -1);

        repeat (10) begin
            int src;
            int len;
            src = int'($urandom % 4);
            len = int'($urandom % 64);
            h = {};
            for (int i = 0; i <= len; i++) h.push_back(1'($urandom));
            run_fill(src, len, h, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
